slice_serializer: RTL

Parametrised word-to-slice serializer, the next generation of the two-phase nibble register FSM. Captures one IN_W-bit word through a valid/ready handshake and emits NUM_SLICES consecutive SLICE_W-bit slices downstream, one per accepted beat, with first/last markers. It sits between the CPU-side register interface and the Hamming encoder datapath, and supports back-pressure and back-to-back words.

---
 rtl/slice_serializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/slice_serializer.sv
// slice_serializer: captures one IN_W-bit word over a valid/ready handshake and
// emits NUM_SLICES SLICE_W-bit slices downstream with first/last markers.
// Supports back-pressure and zero-bubble back-to-back words.
// Optional feature macro: SER_WORD_CNT_EN adds a 16-bit wrapping count of
// completed words on the word_count port.
//
// state | meaning
// IDLE  | no word held, in_ready high, out_valid low
// SEND  | word held, slices pending, out_valid high
module slice_serializer #(
    parameter int IN_W       = 32,
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 2,
    parameter int MSB_FIRST  = 0,
    localparam int IDX_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_data,
    output logic               out_first,
    output logic               out_last,
    output logic [IDX_W-1:0]   slice_idx
`ifdef SER_WORD_CNT_EN
    ,
    output logic [15:0]        word_count
`endif
);

    // Only the low NUM_SLICES*SLICE_W bits of a word are ever emitted.
    localparam int HELD_W = (NUM_SLICES < 1) ? SLICE_W : NUM_SLICES * SLICE_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'((NUM_SLICES < 1) ? 0 : NUM_SLICES - 1);

    generate
        if ((NUM_SLICES < 1) || (NUM_SLICES * SLICE_W > IN_W)) begin : g_bad_params
            $error("slice_serializer: NUM_SLICES must be 1..IN_W/SLICE_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    beat;
    logic [IDX_W-1:0]    beat_nxt;
    logic [HELD_W-1:0]   held;
    logic [HELD_W-1:0]   held_nxt;
    logic [IDX_W-1:0]    sel;
    logic                beat_acc;
    logic                last_acc;
    logic                unused_in;

    // Upper input bits are intentionally ignored.
    assign unused_in = ^in_data;

    assign out_valid = (state == SEND);
    assign out_first = (beat == '0);
    assign out_last  = (beat == LAST_BEAT);
    assign slice_idx = beat;
    assign beat_acc  = out_valid && out_ready;
    assign last_acc  = beat_acc && out_last;
    // in_ready depends on out_ready only, never on in_valid.
    assign in_ready  = (state == IDLE) || last_acc;

    // Select the slice for the current beat from the held word.
    always_comb begin
        sel      = (MSB_FIRST != 0) ? (LAST_BEAT - beat) : beat;
        out_data = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (sel == IDX_W'(k)) begin
                out_data = held[k*SLICE_W +: SLICE_W];
            end
        end
    end

    // Next-state, beat and held-word logic.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        held_nxt  = held;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    held_nxt  = in_data[HELD_W-1:0];
                    beat_nxt  = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (beat_acc) begin
                    if (!out_last) begin
                        beat_nxt = beat + IDX_W'(1);
                    end else if (in_valid) begin
                        // Zero-bubble: next word captured on the last-beat edge.
                        held_nxt = in_data[HELD_W-1:0];
                        beat_nxt = '0;
                    end else begin
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // State, beat and held-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            held  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            held  <= held_nxt;
        end
    end

`ifdef SER_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    // Completed-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (last_acc) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_count = word_cnt_q;
`endif

endmodule
